// File: rtl/vga_stream_ctrl.sv
// vga_stream_ctrl
// Pixel-domain sequencer that sits between the SDRAM->async FIFO reader and the
// VGA timing generator. It holds display timing at the origin until the FIFO has
// pre-filled. It then gates FIFO reads to active pixels. On a FIFO underrun it
// blanks the rest of the corrupted frame. At the next frame origin it runs a
// toggle req/ack resync with the wishbone-side reader (flush FIFO, rewind
// address) and then refills before restarting on a clean frame.
//
// Build option: define VGA_STREAM_SOFT_UNDERRUN_EN to make underruns "soft".
// A soft underrun only masks the pixel and counts the event; the sequencer
// stays in S_RUN, and the drain/resync path is never entered.
module vga_stream_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int FILL_HOLD   = 4,
   parameter int CNT_W       = 16
) (
   input  logic             pixel_clk,
   input  logic             pixel_rst,
   input  logic             fifo_wfull,
   input  logic             fifo_rempty,
   input  logic             pix_active,
   input  logic             frame_start,
   output logic             timing_en,
   output logic             fifo_read,
   output logic             rgb_mask,
   output logic             resync_req,
   input  logic             resync_ack,
   output logic [CNT_W-1:0] underrun_cnt,
   output logic [1:0]       state
);

   localparam int                    FILL_CNT_W  = $clog2(FILL_HOLD + 1);
   localparam logic [FILL_CNT_W-1:0] FILL_HOLD_C = FILL_CNT_W'(FILL_HOLD);
   localparam logic [FILL_CNT_W-1:0] FILL_ZERO_C = {FILL_CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_MAX_C   = {CNT_W{1'b1}};

   // S_DRAIN's code is shared by the resync wait; resync_r tells the two apart.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                 state_r;
   logic                   resync_r;
   logic [FILL_CNT_W-1:0]  fill_cnt_r;
   logic                   timing_en_r;
   logic                   resync_req_r;
   logic [CNT_W-1:0]       underrun_cnt_r;
   logic [SYNC_STAGES-1:0] wfull_sync_r;
   logic [SYNC_STAGES-1:0] ack_sync_r;

   logic wfull_s;
   logic ack_s;
   logic run_s;
   logic underrun_s;

   // Saturating increment for the underrun event counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX_C) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   // Bring the wshb-domain full flag and resync acknowledge into the pixel domain.
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         wfull_sync_r <= {SYNC_STAGES{1'b0}};
         ack_sync_r   <= {SYNC_STAGES{1'b0}};
      end else begin
         wfull_sync_r <= {wfull_sync_r[SYNC_STAGES-2:0], fifo_wfull};
         ack_sync_r   <= {ack_sync_r[SYNC_STAGES-2:0], resync_ack};
      end
   end

   assign wfull_s = wfull_sync_r[SYNC_STAGES-1];
   assign ack_s   = ack_sync_r[SYNC_STAGES-1];

   // Per-pixel read gating and masking; any non-RUN state blanks active pixels.
   always_comb begin
      run_s      = (state_r == S_RUN);
      underrun_s = run_s & pix_active & fifo_rempty;
      fifo_read  = run_s & pix_active & ~fifo_rempty;
      rgb_mask   = pix_active & (~run_s | fifo_rempty);
   end

   // Sequencer: prefill hold, streaming, drain to frame origin, and req/ack resync.
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         state_r        <= S_IDLE;
         resync_r       <= 1'b0;
         fill_cnt_r     <= FILL_ZERO_C;
         timing_en_r    <= 1'b0;
         resync_req_r   <= 1'b0;
         underrun_cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               state_r     <= S_FILL;
               resync_r    <= 1'b0;
               fill_cnt_r  <= FILL_ZERO_C;
               timing_en_r <= 1'b0;
            end
            S_FILL: begin
               // A wfull_s dropout restarts the hold; the move to RUN happens one
               // cycle after the count reaches FILL_HOLD.
               if (fill_cnt_r == FILL_HOLD_C) begin
                  state_r     <= S_RUN;
                  timing_en_r <= 1'b1;
                  fill_cnt_r  <= FILL_ZERO_C;
               end else if (wfull_s) begin
                  fill_cnt_r <= fill_cnt_r + FILL_CNT_W'(1);
               end else begin
                  fill_cnt_r <= FILL_ZERO_C;
               end
            end
            S_RUN: begin
               // An underrun beats any frame_start that coincides with it.
               if (underrun_s) begin
                  underrun_cnt_r <= sat_inc(underrun_cnt_r);
`ifdef VGA_STREAM_SOFT_UNDERRUN_EN
                  state_r <= S_RUN;
`else
                  state_r <= S_DRAIN;
`endif
               end else begin
                  state_r <= S_RUN;
               end
            end
            S_DRAIN: begin
               if (!resync_r) begin
                  // Let the corrupted frame finish; recovery starts only at origin.
                  if (frame_start) begin
                     resync_req_r <= ~resync_req_r;
                     timing_en_r  <= 1'b0;
                     resync_r     <= 1'b1;
                  end else begin
                     resync_r <= 1'b0;
                  end
               end else begin
                  // The wshb reader echoes the toggle once flush and rewind are done.
                  if (ack_s == resync_req_r) begin
                     state_r    <= S_FILL;
                     resync_r   <= 1'b0;
                     fill_cnt_r <= FILL_ZERO_C;
                  end else begin
                     resync_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign timing_en    = timing_en_r;
   assign resync_req   = resync_req_r;
   assign underrun_cnt = underrun_cnt_r;
   assign state        = state_r;

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// tb_vga_stream_ctrl
// Randomized bench for vga_stream_ctrl with a phase-level reference model.
// It emulates a small VGA timing generator and the wshb-side resync reader.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_vga_stream_ctrl;
   localparam int SYNC_STAGES = 2;
   localparam int FILL_HOLD   = 4;
   localparam int CNT_W       = 16;
   localparam int CNT_W_B     = 2;
   localparam longint CNT_MAX   = (longint'(1) << CNT_W) - 1;
   localparam longint CNT_MAX_B = (longint'(1) << CNT_W_B) - 1;

   // Tiny raster: origin (0,0) lies in blanking.
   localparam int H_TOTAL = 48, H_ACT_START = 4, H_ACT = 40;
   localparam int V_TOTAL = 6,  V_ACT_START = 1, V_ACT = 4;
   localparam int FRAME_CYC = H_TOTAL * V_TOTAL;
   localparam int FRAME_PX  = H_ACT * V_ACT;

   logic pixel_clk   = 1'b0;
   logic pixel_rst   = 1'b1;
   logic fifo_wfull  = 1'b0;
   logic fifo_rempty = 1'b0;
   logic pix_active  = 1'b0;
   logic frame_start = 1'b0;
   logic resync_ack  = 1'b0;

   logic               timing_en, fifo_read, rgb_mask, resync_req;
   logic [CNT_W-1:0]   underrun_cnt;
   logic [1:0]         state;
   logic               timing_en_b, fifo_read_b, rgb_mask_b, resync_req_b;
   logic [CNT_W_B-1:0] underrun_cnt_b;
   logic [1:0]         state_b;

   vga_stream_ctrl #(.SYNC_STAGES(SYNC_STAGES), .FILL_HOLD(FILL_HOLD), .CNT_W(CNT_W)) dut (
      .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .fifo_wfull(fifo_wfull),
      .fifo_rempty(fifo_rempty), .pix_active(pix_active), .frame_start(frame_start),
      .timing_en(timing_en), .fifo_read(fifo_read), .rgb_mask(rgb_mask),
      .resync_req(resync_req), .resync_ack(resync_ack), .underrun_cnt(underrun_cnt),
      .state(state));

   vga_stream_ctrl #(.SYNC_STAGES(SYNC_STAGES), .FILL_HOLD(FILL_HOLD), .CNT_W(CNT_W_B)) dut_b (
      .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .fifo_wfull(fifo_wfull),
      .fifo_rempty(fifo_rempty), .pix_active(pix_active), .frame_start(frame_start),
      .timing_en(timing_en_b), .fifo_read(fifo_read_b), .rgb_mask(rgb_mask_b),
      .resync_req(resync_req_b), .resync_ack(resync_ack), .underrun_cnt(underrun_cnt_b),
      .state(state_b));

   always #5 pixel_clk = ~pixel_clk;

   // Reference model: phase 0 idle, 1 fill, 2 run, 3 drain, 4 resync wait.
   int     m_ph;
   int     m_streak;
   bit     m_req;
   longint m_unders;
   bit     wq[$];
   bit     aq[$];
   int     hpos, vpos;
   int     ack_wait;

   // Stimulus controls.
   int  wf_mode;    // 0 random, 1 steady high, 2 pattern then high
   bit  wf_pat[$];
   bit  rnd_re;
   int  inject_px;
   int  ack_hold;   // -1: random reader latency
   bit  noise;
   int  fr_reads;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_state();
      return (m_ph == 4) ? 2'd3 : 2'(m_ph);
   endfunction

   function automatic bit exp_te();
      return (m_ph == 2) || (m_ph == 3);
   endfunction

   function automatic bit tg_active();
      return (vpos >= V_ACT_START) && (vpos < V_ACT_START + V_ACT) &&
             (hpos >= H_ACT_START) && (hpos < H_ACT_START + H_ACT);
   endfunction

   function automatic int tg_px();
      return (vpos - V_ACT_START) * H_ACT + (hpos - H_ACT_START);
   endfunction

   task automatic model_reset();
      m_ph = 0; m_streak = 0; m_req = 1'b0; m_unders = 0;
      wq.delete(); aq.delete();
      hpos = 0; vpos = 0;
   endtask

   task automatic model_edge();
      bit ws, as, te_pre;
      ws = (wq.size() >= SYNC_STAGES) ? wq[SYNC_STAGES-1] : 1'b0;
      as = (aq.size() >= SYNC_STAGES) ? aq[SYNC_STAGES-1] : 1'b0;
      te_pre = exp_te();
      case (m_ph)
         0: begin m_ph = 1; m_streak = 0; end
         1: begin
            if (m_streak == FILL_HOLD) m_ph = 2;
            else if (ws) m_streak++;
            else m_streak = 0;
         end
         2: begin
            if (pix_active && fifo_rempty) begin
               m_unders++;
`ifndef VGA_STREAM_SOFT_UNDERRUN_EN
               m_ph = 3;
`endif
            end
         end
         3: begin
            if (frame_start) begin
               m_req = !m_req;
               m_ph = 4;
               ack_wait = (ack_hold >= 0) ? ack_hold : int'($urandom_range(60, 0));
            end
         end
         4: begin
            if (as == m_req) begin m_ph = 1; m_streak = 0; end
         end
         default: m_ph = 0;
      endcase
      wq.push_front(fifo_wfull);
      if (wq.size() > SYNC_STAGES) void'(wq.pop_back());
      aq.push_front(resync_ack);
      if (aq.size() > SYNC_STAGES) void'(aq.pop_back());
      // Timing generator: free-runs while enabled, otherwise parked at origin.
      if (!te_pre) begin
         hpos = 0; vpos = 0;
      end else begin
         hpos++;
         if (hpos == H_TOTAL) begin
            hpos = 0; vpos++;
            if (vpos == V_TOTAL) vpos = 0;
         end
      end
   endtask

   task automatic gen_inputs();
      bit te;
      te = exp_te();
      case (wf_mode)
         1: fifo_wfull = 1'b1;
         2: fifo_wfull = (wf_pat.size() > 0) ? wf_pat.pop_front() : 1'b1;
         default: fifo_wfull = ($urandom_range(7, 0) != 0);
      endcase
      if (te) begin
         pix_active  = tg_active();
         frame_start = (hpos == 0) && (vpos == 0);
      end else begin
         pix_active  = 1'($urandom_range(1, 0));
         frame_start = ($urandom_range(15, 0) == 0);
      end
      if (noise && $urandom_range(49, 0) == 0) begin
         pix_active  = 1'($urandom_range(1, 0));
         frame_start = 1'($urandom_range(1, 0));
      end
      if (m_ph == 2 && pix_active) begin
         if (inject_px >= 0 && te && tg_active() && tg_px() == inject_px) begin
            fifo_rempty = 1'b1;
            inject_px = -1;
         end else if (rnd_re) begin
            fifo_rempty = ($urandom_range(99, 0) == 0);
         end else begin
            fifo_rempty = 1'b0;
         end
      end else begin
         fifo_rempty = 1'($urandom_range(1, 0));
      end
      // wshb-side reader: echo the request toggle after its latency.
      if (resync_ack != m_req) begin
         if (ack_wait == 0) resync_ack = m_req;
         else ack_wait--;
      end
   endtask

   task automatic compare_all();
      longint ec, ecb;
      ec  = (m_unders > CNT_MAX)   ? CNT_MAX   : m_unders;
      ecb = (m_unders > CNT_MAX_B) ? CNT_MAX_B : m_unders;
      chk("state",          64'(state),          64'(exp_state()));
      chk("timing_en",      64'(timing_en),      64'(exp_te()));
      chk("fifo_read",      64'(fifo_read),      64'((m_ph == 2) && pix_active && !fifo_rempty));
      chk("rgb_mask",       64'(rgb_mask),       64'(pix_active && ((m_ph != 2) || fifo_rempty)));
      chk("resync_req",     64'(resync_req),     64'(m_req));
      chk("underrun_cnt",   64'(underrun_cnt),   64'(ec));
      chk("state_b",        64'(state_b),        64'(exp_state()));
      chk("timing_en_b",    64'(timing_en_b),    64'(exp_te()));
      chk("fifo_read_b",    64'(fifo_read_b),    64'((m_ph == 2) && pix_active && !fifo_rempty));
      chk("rgb_mask_b",     64'(rgb_mask_b),     64'(pix_active && ((m_ph != 2) || fifo_rempty)));
      chk("resync_req_b",   64'(resync_req_b),   64'(m_req));
      chk("underrun_cnt_b", 64'(underrun_cnt_b), 64'(ecb));
      if (fifo_read) fr_reads++;
   endtask

   task automatic cycle(input bit rst);
      @(negedge pixel_clk);
      gen_inputs();
      pixel_rst = rst;
      if (rst) begin
         model_reset();
         resync_ack = 1'b0;
         ack_wait = 0;
      end
      #1;
      compare_all();
      @(posedge pixel_clk);
      if (!rst) model_edge();
   endtask

   initial begin
      int n;
      model_reset();
      wf_mode = 1; rnd_re = 1'b0; inject_px = -1; ack_hold = -1; noise = 1'b0;
      ack_wait = 0; fr_reads = 0;

      // Reset, then steady wfull: timing starts SYNC_STAGES+FILL_HOLD+1 edges later.
      repeat (3) cycle(1'b1);
      n = 0;
      do begin cycle(1'b0); n++; #1; end while (!timing_en && n < 50);
      chk("fill_latency", 64'(n), 64'(SYNC_STAGES + FILL_HOLD + 1));

      // Clean streaming for one frame: one read per active pixel.
      fr_reads = 0;
      repeat (FRAME_CYC) cycle(1'b0);
      chk("frame_reads", 64'(fr_reads), 64'(FRAME_PX));

      // Underrun at active pixel 100, reader holds its ack for 50 cycles.
      inject_px = 100;
      ack_hold = 50;
      repeat (3 * FRAME_CYC) cycle(1'b0);
      #1;
      chk("dir_underrun_cnt", 64'(underrun_cnt), 64'd1);
`ifdef VGA_STREAM_SOFT_UNDERRUN_EN
      chk("dir_resync_req", 64'(resync_req), 64'd0);
`else
      chk("dir_resync_req", 64'(resync_req), 64'd1);
`endif
      chk("dir_state", 64'(state), 64'd2);
      chk("dir_timing_en", 64'(timing_en), 64'd1);

      // wfull 1,1,1,0 then steady: the dropout restarts the hold count.
      repeat (2) cycle(1'b1);
      wf_pat = '{1'b1, 1'b1, 1'b1, 1'b0};
      wf_mode = 2;
      n = 0;
      do begin cycle(1'b0); n++; #1; end while (!timing_en && n < 50);
      chk("fill_restart_latency", 64'(n), 64'(SYNC_STAGES + FILL_HOLD + 5));

`ifndef VGA_STREAM_SOFT_UNDERRUN_EN
      // Reset while waiting for the resync ack.
      wf_mode = 1;
      ack_hold = 400;
      inject_px = 10;
      n = 0;
      while (m_ph != 4 && n < 2000) begin cycle(1'b0); n++; end
      repeat (3) cycle(1'b0);
      #1;
      chk("resync_wait_state", 64'(state), 64'd3);
      chk("resync_wait_req", 64'(resync_req), 64'd1);
      repeat (2) cycle(1'b1);
      #1;
      chk("req_after_reset", 64'(resync_req), 64'd0);
`endif

      // Randomized phase with noise, random underruns and rare resets.
      wf_mode = 0; rnd_re = 1'b1; noise = 1'b1; ack_hold = -1; inject_px = -1;
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(5999, 0) == 0) begin
            repeat (2) cycle(1'b1);
         end else begin
            cycle(1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
